ts_match_counter: RTL and testbench

Consumes decoded ordered sets from the ordered-set decode stage and tracks consecutive identical TS1/TS2 ordered sets, consecutive idle data, and inactivity, producing the qualified counts and captured training fields that the LTSSM uses for state exits (e.g. 8 consecutive TS1, 8 idle). It sits directly downstream of the ordered-set decoder, one per lane, and upstream of the LTSSM.

---
 rtl/ts_match_counter.sv | 115 +++++++++++
 tb/tb_ts_match_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ts_match_counter.sv
// ts_match_counter: tracks consecutive identical TS1/TS2, idle run length and TS inactivity for one lane
module ts_match_counter #(
    parameter int TIMEOUT_CYCLES = 2400000,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [127:0]         ordered_set_i,
    input  logic                 ts1_valid_i,
    input  logic                 ts2_valid_i,
    input  logic                 eieos_valid_i,
    input  logic                 idle_valid_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] ts1_count_o,
    output logic [CNT_WIDTH-1:0] ts2_count_o,
    output logic [CNT_WIDTH-1:0] idle_count_o,
    output logic [7:0]           link_num_o,
    output logic [7:0]           lane_num_o,
    output logic [7:0]           nfts_o,
    output logic [7:0]           rate_id_o,
    output logic [7:0]           training_ctrl_o,
    output logic                 link_pad_o,
    output logic                 lane_pad_o,
    output logic                 last_is_ts2_o,
    output logic                 eieos_seen_o,
    output logic                 timeout_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE = TW'(1);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    localparam logic [7:0] PAD = 8'hF7;

    typedef enum logic [1:0] {T_NONE, T_TS1, T_TS2} ts_t;

    ts_t                  prev_type;
    logic [119:0]         prev_body;
    logic [TW-1:0]        to_cnt;
    logic                 ts_acc;
    logic                 match;
    logic [CNT_WIDTH-1:0] ts1_next;
    logic [CNT_WIDTH-1:0] ts2_next;
    logic [CNT_WIDTH-1:0] idle_inc;
    logic                 unused_sym0;

    // Symbol 0 (COM / identifier) carries no training information here.
    assign unused_sym0 = ^ordered_set_i[7:0];

    // A TS continues a run only if it repeats the previous type and body; a mismatch restarts at 1.
    always_comb begin
        ts_acc   = ts1_valid_i ^ ts2_valid_i;
        match    = (ordered_set_i[127:8] == prev_body) &&
                   (prev_type == (ts1_valid_i ? T_TS1 : T_TS2));
        ts1_next = !ts1_valid_i ? '0 : !match ? ONE : (ts1_count_o == MAX) ? MAX : ts1_count_o + ONE;
        ts2_next = !ts2_valid_i ? '0 : !match ? ONE : (ts2_count_o == MAX) ? MAX : ts2_count_o + ONE;
        idle_inc = (idle_count_o == MAX) ? MAX : idle_count_o + ONE;
    end

    // Event priority: reset, then clear, then an accepted TS, then idle; corrupt TS cycles only age the timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts1_count_o     <= '0;
            ts2_count_o     <= '0;
            idle_count_o    <= '0;
            link_num_o      <= '0;
            lane_num_o      <= '0;
            nfts_o          <= '0;
            rate_id_o       <= '0;
            training_ctrl_o <= '0;
            link_pad_o      <= 1'b0;
            lane_pad_o      <= 1'b0;
            last_is_ts2_o   <= 1'b0;
            eieos_seen_o    <= 1'b0;
            timeout_o       <= 1'b0;
            prev_type       <= T_NONE;
            prev_body       <= '0;
            to_cnt          <= '0;
        end else if (clear_i) begin
            ts1_count_o  <= '0;
            ts2_count_o  <= '0;
            idle_count_o <= '0;
            eieos_seen_o <= 1'b0;
            timeout_o    <= 1'b0;
            prev_type    <= T_NONE;
            to_cnt       <= '0;
        end else begin
            if (eieos_valid_i)
                eieos_seen_o <= 1'b1;
            if (ts_acc) begin
                ts1_count_o     <= ts1_next;
                ts2_count_o     <= ts2_next;
                idle_count_o    <= '0;
                to_cnt          <= '0;
                prev_type       <= ts1_valid_i ? T_TS1 : T_TS2;
                prev_body       <= ordered_set_i[127:8];
                link_num_o      <= ordered_set_i[15:8];
                lane_num_o      <= ordered_set_i[23:16];
                nfts_o          <= ordered_set_i[31:24];
                rate_id_o       <= ordered_set_i[39:32];
                training_ctrl_o <= ordered_set_i[47:40];
                link_pad_o      <= ordered_set_i[15:8] == PAD;
                lane_pad_o      <= ordered_set_i[23:16] == PAD;
                last_is_ts2_o   <= ts2_valid_i;
            end else begin
                if (idle_valid_i && !ts1_valid_i)
                    idle_count_o <= idle_inc;
                if (to_cnt == TO_MAX)
                    timeout_o <= 1'b1;
                else
                    to_cnt <= to_cnt + TO_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ts_match_counter.sv
// tb_ts_match_counter: directed vectors with a queued scoreboard for ts_match_counter
module tb_ts_match_counter;
    localparam logic [10:0] CNTS = 11'h007, FLD = 11'h038, PADS = 11'h0C0,
                            L2 = 11'h100, EI = 11'h200, TO = 11'h400, ALL = 11'h7FF;

    typedef struct packed {
        logic [10:0] m;
        logic [4:0]  t1, t2, id;
        logic [7:0]  link, lane, nfts;
        logic        lp, np, l2, ei, to;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0, clear_i = 1'b0;
    logic         ts1_valid_i = 1'b0, ts2_valid_i = 1'b0, eieos_valid_i = 1'b0, idle_valid_i = 1'b0;
    logic [127:0] ordered_set_i = '0;
    logic [4:0]   ts1_count_o, ts2_count_o, idle_count_o;
    logic [7:0]   link_num_o, lane_num_o, nfts_o, rate_id_o, training_ctrl_o;
    logic         link_pad_o, lane_pad_o, last_is_ts2_o, eieos_seen_o, timeout_o;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ts_match_counter #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .ordered_set_i(ordered_set_i),
        .ts1_valid_i(ts1_valid_i), .ts2_valid_i(ts2_valid_i),
        .eieos_valid_i(eieos_valid_i), .idle_valid_i(idle_valid_i), .clear_i(clear_i),
        .ts1_count_o(ts1_count_o), .ts2_count_o(ts2_count_o), .idle_count_o(idle_count_o),
        .link_num_o(link_num_o), .lane_num_o(lane_num_o), .nfts_o(nfts_o),
        .rate_id_o(rate_id_o), .training_ctrl_o(training_ctrl_o),
        .link_pad_o(link_pad_o), .lane_pad_o(lane_pad_o), .last_is_ts2_o(last_is_ts2_o),
        .eieos_seen_o(eieos_seen_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input logic [7:0] link, lane, nfts);
        mk = {{10{8'h4A}}, 8'h00, 8'h02, nfts, lane, link, 8'hBC};
    endfunction

    function automatic exp_t ce(input logic [10:0] m, input int a, b, c);
        exp_t e;
        e = '0;
        e.m = m;
        e.t1 = 5'(a);
        e.t2 = 5'(b);
        e.id = 5'(c);
        return e;
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc(input logic r, c, a, b, e, i, input logic [127:0] os, input exp_t x);
        @(negedge clk);
        rst_i = r; clear_i = c; ts1_valid_i = a; ts2_valid_i = b;
        eieos_valid_i = e; idle_valid_i = i; ordered_set_i = os;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.m[0])  chk("ts1_count",   8'(ts1_count_o),   8'(e.t1));
                if (e.m[1])  chk("ts2_count",   8'(ts2_count_o),   8'(e.t2));
                if (e.m[2])  chk("idle_count",  8'(idle_count_o),  8'(e.id));
                if (e.m[3])  chk("link_num",    link_num_o,        e.link);
                if (e.m[4])  chk("lane_num",    lane_num_o,        e.lane);
                if (e.m[5])  chk("nfts",        nfts_o,            e.nfts);
                if (e.m[6])  chk("link_pad",    8'(link_pad_o),    8'(e.lp));
                if (e.m[7])  chk("lane_pad",    8'(lane_pad_o),    8'(e.np));
                if (e.m[8])  chk("last_is_ts2", 8'(last_is_ts2_o), 8'(e.l2));
                if (e.m[9])  chk("eieos_seen",  8'(eieos_seen_o),  8'(e.ei));
                if (e.m[10]) chk("timeout",     8'(timeout_o),     8'(e.to));
            end
        end
    end

    initial begin : stim
        exp_t e;
        logic [127:0] os_a, os_b;
        int n, seen;
        os_a = mk(8'h00, 8'h01, 8'h20);
        os_b = mk(8'h00, 8'h02, 8'h20);
        // reset state
        cyc(1, 0, 0, 0, 0, 0, '0, ce(ALL, 0, 0, 0));
        // timeout rises 16 cycles after reset release
        for (int k = 1; k <= 16; k++) begin
            e = ce(TO, 0, 0, 0);
            e.to = (k == 16);
            cyc(0, 0, 0, 0, 0, 0, '0, e);
        end
        cyc(0, 1, 0, 0, 0, 0, '0, ce(ALL, 0, 0, 0));
        // 8 identical TS1
        for (int k = 1; k <= 8; k++) begin
            e = ce(CNTS | FLD | L2 | TO, k, 0, 0);
            e.lane = 8'h01; e.nfts = 8'h20;
            cyc(0, 0, 1, 0, 0, 0, os_a, e);
        end
        // clear keeps captured fields
        e = ce(CNTS | FLD, 0, 0, 0);
        e.lane = 8'h01; e.nfts = 8'h20;
        cyc(0, 1, 0, 0, 0, 0, '0, e);
        // 4 TS1 then lane change, then a corrupt pulse
        for (int k = 1; k <= 4; k++) cyc(0, 0, 1, 0, 0, 0, os_a, ce(CNTS, k, 0, 0));
        e = ce(CNTS | FLD, 1, 0, 0);
        e.lane = 8'h02; e.nfts = 8'h20;
        cyc(0, 0, 1, 0, 0, 0, os_b, e);
        cyc(0, 0, 1, 1, 0, 0, mk(8'h00, 8'h05, 8'h20), e);
        e.t1 = 5'd2;
        cyc(0, 0, 1, 0, 0, 0, os_b, e);
        // 3 TS1 then 2 TS2
        cyc(0, 1, 0, 0, 0, 0, '0, ce(CNTS, 0, 0, 0));
        for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 0, 0, 0, os_a, ce(CNTS | L2, k, 0, 0));
        e = ce(CNTS | L2, 0, 1, 0);
        e.l2 = 1'b1;
        cyc(0, 0, 0, 1, 0, 0, os_a, e);
        e.t2 = 5'd2;
        cyc(0, 0, 0, 1, 0, 0, os_a, e);
        // 40 TS2 with interleaved EIEOS: saturation at 31
        cyc(0, 1, 0, 0, 0, 0, '0, ce(CNTS | EI, 0, 0, 0));
        n = 0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (k % 5 == 4) seen = 1;
            else n++;
            e = ce(CNTS | EI, 0, (n > 31) ? 31 : n, 0);
            e.ei = seen[0];
            if (k % 5 == 4) cyc(0, 0, 0, 0, 1, 0, '0, e);
            else cyc(0, 0, 0, 1, 0, 0, os_a, e);
        end
        // idle run, then TS1 with PAD link/lane
        cyc(0, 1, 0, 0, 0, 0, '0, ce(CNTS | EI, 0, 0, 0));
        for (int k = 1; k <= 8; k++) cyc(0, 0, 0, 0, 0, 1, '0, ce(CNTS, 0, 0, k));
        e = ce(CNTS | FLD | PADS, 1, 0, 0);
        e.link = 8'hF7; e.lane = 8'hF7; e.nfts = 8'h20; e.lp = 1'b1; e.np = 1'b1;
        cyc(0, 0, 1, 0, 0, 0, mk(8'hF7, 8'hF7, 8'h20), e);
        // reset with clear mid-sequence, first TS after yields 1
        cyc(0, 0, 1, 0, 0, 0, mk(8'hF7, 8'hF7, 8'h20), ce(CNTS, 2, 0, 0));
        cyc(1, 1, 1, 0, 0, 0, os_a, ce(ALL, 0, 0, 0));
        e = ce(CNTS | FLD, 1, 0, 0);
        e.lane = 8'h01; e.nfts = 8'h20;
        cyc(0, 0, 1, 0, 0, 0, os_a, e);
        cyc(0, 0, 0, 0, 0, 0, '0, ce(11'h000, 0, 0, 0));
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
